// File: rtl/data_mem_resp_pkg.sv
// Shared constants for the data-memory responder.
// Holds the bus widths, the MMIO base address, the MMIO register offsets and
// the bit positions of the console status register.
package data_mem_resp_pkg;

    localparam int unsigned DMR_ADDR_WIDTH = 32;
    localparam int unsigned DMR_DATA_WIDTH = 32;
    localparam logic [31:0] DMR_MMIO_BASE  = 32'h1000_0000;

    // MMIO register offsets within the 256-byte window
    localparam logic [7:0] OFS_MTIME_LO    = 8'h00;
    localparam logic [7:0] OFS_MTIME_HI    = 8'h04;
    localparam logic [7:0] OFS_MTIMECMP_LO = 8'h08;
    localparam logic [7:0] OFS_MTIMECMP_HI = 8'h0C;
    localparam logic [7:0] OFS_CONS_TX     = 8'h10;
    localparam logic [7:0] OFS_CONS_STAT   = 8'h14;

    // CONS_STAT bit positions
    localparam int unsigned STAT_FULL    = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_CNT_LSB = 2;
    localparam int unsigned STAT_CNT_W   = 3;
    localparam int unsigned STAT_OVF     = 5;

endpackage

// File: rtl/resp_sync_fifo.sv
// Synchronous FIFO with push/pop handshake and occupancy count.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, wdata       write request and data (ignored when full unless popping)
//   pop               read request (ignored when empty)
//   rdata             head entry, stable until popped; 0 after reset
//   full, empty       occupancy flags
//   count             number of stored entries (0..DEPTH)
module resp_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot the push is about to use
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_resp.sv
// Responder for the core's data-memory port: word RAM plus an MMIO window
// with a 64-bit machine timer and a console TX FIFO.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   ram_ce_i, ram_we_i    access strobe and write enable
//   ram_addr_i            byte address ([1:0] ignored)
//   ram_wdata_i           write data (full word)
//   ram_rdata_o           combinational read data, 0 when not a mapped read
//   bus_err_o             one-cycle pulse after an unmapped access
//   timer_irq_o           registered mtime >= mtimecmp
//   tx_valid_o, tx_data_o console byte stream (FIFO head)
//   tx_ready_i            sink accepts the byte
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DMR_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DMR_DATA_WIDTH,
    parameter int unsigned RAM_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE  = DMR_MMIO_BASE,
    parameter int unsigned TICK_DIV   = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ram_ce_i,
    input  logic                  ram_we_i,
    input  logic [ADDR_WIDTH-1:0] ram_addr_i,
    input  logic [DATA_WIDTH-1:0] ram_wdata_i,
    output logic [DATA_WIDTH-1:0] ram_rdata_o,
    output logic                  bus_err_o,
    output logic                  timer_irq_o,
    output logic                  tx_valid_o,
    output logic [7:0]            tx_data_o,
    input  logic                  tx_ready_i
);

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Address decode
    logic            is_ram;
    logic            is_mmio;
    logic [7:0]      ofs;
    logic [RAM_AW-1:0] ram_idx;
    logic            rd_en;
    logic            mmio_wr;

    assign is_ram  = (ram_addr_i[ADDR_WIDTH-1:RAM_AW+2] == '0);
    assign is_mmio = (ram_addr_i[ADDR_WIDTH-1:8] == MMIO_BASE[ADDR_WIDTH-1:8]);
    assign ofs     = {ram_addr_i[7:2], 2'b00};
    assign ram_idx = ram_addr_i[RAM_AW+1:2];
    assign rd_en   = ram_ce_i && !ram_we_i;
    assign mmio_wr = ram_ce_i && ram_we_i && is_mmio && !is_ram;

    logic wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_cons_tx, wr_cons_stat;
    assign wr_mtime_lo  = mmio_wr && (ofs == OFS_MTIME_LO);
    assign wr_mtime_hi  = mmio_wr && (ofs == OFS_MTIME_HI);
    assign wr_cmp_lo    = mmio_wr && (ofs == OFS_MTIMECMP_LO);
    assign wr_cmp_hi    = mmio_wr && (ofs == OFS_MTIMECMP_HI);
    assign wr_cons_tx   = mmio_wr && (ofs == OFS_CONS_TX);
    assign wr_cons_stat = mmio_wr && (ofs == OFS_CONS_STAT);

    logic unused_addr;
    assign unused_addr = ^ram_addr_i[1:0];

    // Data RAM, not reset
    logic [DATA_WIDTH-1:0] mem [RAM_WORDS];

    always_ff @(posedge clk_i) begin
        if (ram_ce_i && ram_we_i && is_ram) begin
            mem[ram_idx] <= ram_wdata_i;
        end
    end

    // Machine timer
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [63:0]      mtime_q, mtime_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic             tick;

    always_comb begin
        tick       = (presc_q == PRE_W'(TICK_DIV - 1));
        presc_d    = tick ? '0 : presc_q + PRE_W'(1);
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        // A software write to either half wins over the tick
        if (wr_mtime_lo) mtime_d = {mtime_q[63:32], ram_wdata_i};
        if (wr_mtime_hi) mtime_d = {ram_wdata_i, mtime_q[31:0]};
        if (wr_cmp_lo)   mtimecmp_d = {mtimecmp_q[63:32], ram_wdata_i};
        if (wr_cmp_hi)   mtimecmp_d = {ram_wdata_i, mtimecmp_q[31:0]};
    end

    // Console FIFO
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [CNT_W-1:0] fifo_count;
    logic             ovf_q, ovf_d;

    assign fifo_pop   = !fifo_empty && tx_ready_i;
    assign tx_valid_o = !fifo_empty;

    resp_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk_i),
        .rst_n (rst_i),
        .push  (wr_cons_tx),
        .wdata (ram_wdata_i[7:0]),
        .pop   (fifo_pop),
        .rdata (tx_data_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (wr_cons_tx && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end else if (wr_cons_stat && ram_wdata_i[STAT_OVF]) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            presc_q     <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            timer_irq_o <= 1'b0;
            ovf_q       <= 1'b0;
            bus_err_o   <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            timer_irq_o <= (mtime_q >= mtimecmp_q);
            ovf_q       <= ovf_d;
            bus_err_o   <= ram_ce_i && !is_ram && !is_mmio;
        end
    end

    // Read mux
    logic [STAT_CNT_W-1:0] cnt_sat;
    logic [DATA_WIDTH-1:0] stat;

    always_comb begin
        cnt_sat = (32'(fifo_count) > 32'd7) ? '1 : STAT_CNT_W'(fifo_count);
        stat                                     = '0;
        stat[STAT_FULL]                          = fifo_full;
        stat[STAT_EMPTY]                         = fifo_empty;
        stat[STAT_CNT_LSB +: STAT_CNT_W]         = cnt_sat;
        stat[STAT_OVF]                           = ovf_q;
    end

    always_comb begin
        ram_rdata_o = '0;
        if (rd_en) begin
            if (is_ram) begin
                ram_rdata_o = mem[ram_idx];
            end else if (is_mmio) begin
                case (ofs)
                    OFS_MTIME_LO:    ram_rdata_o = mtime_q[31:0];
                    OFS_MTIME_HI:    ram_rdata_o = mtime_q[63:32];
                    OFS_MTIMECMP_LO: ram_rdata_o = mtimecmp_q[31:0];
                    OFS_MTIMECMP_HI: ram_rdata_o = mtimecmp_q[63:32];
                    OFS_CONS_STAT:   ram_rdata_o = stat;
                    default:         ram_rdata_o = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: RAM, decode errors, timer, console FIFO, reset.
module tb_data_mem_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bus_err;
    logic        irq;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] MTIME_LO = 32'h1000_0000;
    localparam logic [31:0] MTIME_HI = 32'h1000_0004;
    localparam logic [31:0] CMP_LO   = 32'h1000_0008;
    localparam logic [31:0] CMP_HI   = 32'h1000_000C;
    localparam logic [31:0] CONS_TX  = 32'h1000_0010;
    localparam logic [31:0] CONS_ST  = 32'h1000_0014;

    data_mem_resp dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .ram_ce_i    (ce),
        .ram_we_i    (we),
        .ram_addr_i  (addr),
        .ram_wdata_i (wdata),
        .ram_rdata_o (rdata),
        .bus_err_o   (bus_err),
        .timer_irq_o (irq),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ce = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        ce = 1'b1; we = 1'b0; addr = a;
        #1 v = rdata;
        @(negedge clk);
        ce = 1'b0;
    endtask

    logic [31:0] v;

    initial begin
        rst_n = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; wdata = '0; tx_ready = 1'b0;
        #3;
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("idle_rdata", rdata, 32'd0);
        rd(CONS_ST, v); chk("rst_stat", v, 32'h0000_0002);
        rd(CMP_LO, v);  chk("rst_cmp_lo", v, 32'hFFFF_FFFF);
        rd(CMP_HI, v);  chk("rst_cmp_hi", v, 32'hFFFF_FFFF);
        rd(MTIME_HI, v); chk("rst_mtime_hi", v, 32'd0);

        // RAM access
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        wr(32'h0000_0000, 32'hA5A5_A5A5);
        rd(32'h0000_0010, v); chk("ram_rd", v, 32'hDEAD_BEEF);
        rd(32'h0000_0012, v); chk("ram_rd_unaligned", v, 32'hDEAD_BEEF);
        chk("ram_no_err", {31'd0, bus_err}, 32'd0);

        // Unmapped accesses
        rd(32'h2000_0000, v); chk("unmapped_rdata", v, 32'd0);
        chk("unmapped_err_pulse", {31'd0, bus_err}, 32'd1);
        @(negedge clk);
        chk("unmapped_err_clear", {31'd0, bus_err}, 32'd0);
        wr(32'h2000_0000, 32'h1234_5678);
        chk("unmapped_wr_err", {31'd0, bus_err}, 32'd1);
        wr(32'h0000_1000, 32'h8765_4321);
        chk("above_ram_wr_err", {31'd0, bus_err}, 32'd1);
        rd(32'h0000_0000, v); chk("ram_unchanged", v, 32'hA5A5_A5A5);
        rd(32'h1000_0020, v); chk("mmio_unlisted_rd", v, 32'd0);
        chk("mmio_unlisted_no_err", {31'd0, bus_err}, 32'd0);
        rd(CONS_TX, v); chk("cons_tx_rd", v, 32'd0);

        // Timer carry
        wr(MTIME_LO, 32'hFFFF_FFFE);
        wr(MTIME_HI, 32'h0000_0000);
        @(negedge clk);
        @(negedge clk);
        rd(MTIME_LO, v); chk("carry_lo", v, 32'd0);
        rd(MTIME_HI, v); chk("carry_hi", v, 32'd1);
        // mtime is 0x1_00000002 here; after two writes it is 0x1_00000004, cmp = that + 5
        wr(CMP_HI, 32'd1);
        wr(CMP_LO, 32'd9);
        chk("irq_low_after_cmp", {31'd0, irq}, 32'd0);
        repeat (5) @(negedge clk);
        chk("irq_before_rise", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_rise", {31'd0, irq}, 32'd1);
        wr(CMP_HI, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("irq_cleared", {31'd0, irq}, 32'd0);

        // FIFO fill with overflow
        for (int i = 0; i < 5; i++) wr(CONS_TX, 32'h41 + i);
        rd(CONS_ST, v); chk("fill_stat", v, 32'h0000_0031);
        chk("fill_valid", {31'd0, tx_valid}, 32'd1);
        chk("fill_head", {24'd0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("drain_data", {24'd0, tx_data}, 32'h41 + i);
        end
        @(negedge clk);
        chk("drain_empty", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;
        wr(CONS_ST, 32'h0000_0020);
        rd(CONS_ST, v); chk("ovf_cleared", v, 32'h0000_0002);

        // Push and pop in the same cycle while full
        for (int i = 0; i < 4; i++) wr(CONS_TX, 32'h51 + i);
        rd(CONS_ST, v); chk("full_stat", v, 32'h0000_0011);
        tx_ready = 1'b1;
        wr(CONS_TX, 32'h55);
        tx_ready = 1'b0;
        rd(CONS_ST, v); chk("pushpop_stat", v, 32'h0000_0011);
        chk("pushpop_head", {24'd0, tx_data}, 32'h52);
        tx_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("pushpop_drain", {24'd0, tx_data}, 32'h52 + i);
        end
        @(negedge clk);
        chk("pushpop_empty", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // Reset mid-operation
        for (int i = 0; i < 3; i++) wr(CONS_TX, 32'h61 + i);
        wr(CMP_HI, 32'd0);
        wr(CMP_LO, 32'd0);
        @(negedge clk);
        chk("pre_rst_irq", {31'd0, irq}, 32'd1);
        chk("pre_rst_valid", {31'd0, tx_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("async_rst_irq", {31'd0, irq}, 32'd0);
        chk("async_rst_data", {24'd0, tx_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(CONS_ST, v); chk("post_rst_stat", v, 32'h0000_0002);
        chk("post_rst_valid", {31'd0, tx_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Responder for the core's data-memory port (ce/addr/wdata/we, combinational read data). The core's MEM stage is the initiator.
- Serves a word-addressed data RAM and a small MMIO region.
- MMIO region holds a free-running machine timer (mtime/mtimecmp plus timer interrupt) and a console TX FIFO, drained through a valid/ready byte stream.
- Sits beside the core at SoC top level, in place of a bare RAM model.

Parameters:
- ADDR_WIDTH, 32, bus address width
- DATA_WIDTH, 32, bus data width
- RAM_WORDS, 1024, data RAM depth in 32-bit words (power of two)
- MMIO_BASE, 32'h1000_0000, MMIO region base (256-byte aligned)
- TICK_DIV, 1, clock cycles per mtime increment (>=1)
- FIFO_DEPTH, 4, console FIFO entries (power of two, >=2)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-low
- ram_ce_i  in  1  access strobe from core
- ram_we_i  in  1  write when 1, read when 0 (qualified by ce)
- ram_addr_i  in  ADDR_WIDTH  byte address; [1:0] ignored
- ram_wdata_i  in  DATA_WIDTH  write data
- ram_rdata_o  out  DATA_WIDTH  read data, combinational
- bus_err_o  out  1  one-cycle pulse after an unmapped access
- timer_irq_o  out  1  registered (mtime >= mtimecmp)
- tx_valid_o  out  1  console byte available
- tx_data_o  out  8  console byte (FIFO head)
- tx_ready_i  in  1  sink accepts byte

Behaviour:
- Decode (combinational):
  - RAM when addr[31:log2(RAM_WORDS)+2]==0.
  - MMIO when addr[31:8]==MMIO_BASE[31:8].
  - Otherwise unmapped.
- Read: ram_rdata_o valid in the same cycle as ce=1, we=0, with no wait states. It is 0 when ce=0, on a write, on an unmapped access, or on an unlisted MMIO offset.
- Write: takes effect on the rising edge while ce=1 and we=1. Full word only; there are no byte enables.
- MMIO offsets:
  - 0x00 MTIME_LO, RW.
  - 0x04 MTIME_HI, RW.
  - 0x08 MTIMECMP_LO, RW.
  - 0x0C MTIMECMP_HI, RW.
  - 0x10 CONS_TX: W pushes wdata[7:0]; reads 0.
  - 0x14 CONS_STAT: R bit0 full, bit1 empty, bits[4:2] count (saturating field), bit5 overflow sticky. W with bit5=1 clears overflow; all other bits ignored.
  - Other offsets: read 0, writes dropped, no bus error.
- mtime: 64-bit counter.
  - A prescaler counts 0..TICK_DIV-1; mtime += 1 on the wrap, modulo 2^64.
  - Carry from low word into high word happens in the same cycle.
  - A software write to a half loads that half and suppresses the increment that cycle. The prescaler is not reset.
- mtimecmp: 64-bit, unsigned compare.
  - timer_irq_o is registered, so it reflects the compare of the previous cycle's values (one-cycle latency).
  - Writing mtimecmp to a value above mtime deasserts the irq on the following edge.
- Console FIFO:
  - Push when CONS_TX is written and (count<FIFO_DEPTH, or a pop happens in the same cycle).
  - A push to a full FIFO with no pop is dropped and sets overflow.
  - Pop when tx_valid_o and tx_ready_i.
  - tx_valid_o = !empty. tx_data_o = head, held stable until popped. There is no push-to-output bypass: the first byte appears the cycle after the push.
  - Read and write pointers wrap modulo FIFO_DEPTH. count is FIFO_DEPTH+1 values wide.
- bus_err_o: registered. High for exactly one cycle after any ce=1 access to an unmapped address, whether read or write.
- Reset (asynchronous assert, synchronous deassert at top level) sets:
  - mtime = 0 and prescaler = 0.
  - mtimecmp = all ones, so timer_irq_o = 0.
  - FIFO empty and overflow = 0.
  - tx_valid_o = 0, tx_data_o = 0, bus_err_o = 0, timer_irq_o = 0.
  - RAM contents are not reset; they are undefined after reset in simulation.
- Reset asserted mid-transfer: the FIFO contents are discarded, and tx_valid_o drops asynchronously.

Decomposition:
- Shared package or defines:
  - MMIO offset constants (MTIME_LO..CONS_STAT).
  - CONS_STAT bit positions.
  - MMIO_BASE default.
  - The existing ADDR_WIDTH and DATA_WIDTH defines.
- One sub-module: resp_sync_fifo (parameterised width/depth, push/pop/full/empty/count). It is reusable for a later RX path.
- Timer and decode remain in data_mem_resp.

Test Plan:
1. RAM access: write 0xDEADBEEF to 0x0000_0010, then read it back. ram_rdata_o = 0xDEADBEEF in the read cycle. A read of 0x0000_0012 returns the same word.
2. Unmapped access: read 0x2000_0000. ram_rdata_o = 0 and bus_err_o = 1 for exactly one cycle after. A write to 0x2000_0000 leaves RAM unchanged.
3. Timer (TICK_DIV=1):
   - Write MTIME_LO = 0xFFFF_FFFE and MTIME_HI = 0. Two cycles later, MTIME_HI = 1 and MTIME_LO = 0.
   - Write MTIMECMP to mtime+5. timer_irq_o rises 6 cycles later.
   - Writing MTIMECMP_HI = 0xFFFF_FFFF clears the irq the next cycle.
4. FIFO fill (tx_ready_i=0): push 0x41, 0x42, 0x43, 0x44, 0x45. CONS_STAT shows full=1, count=4, overflow=1. Then raise tx_ready_i: the bytes come out as 0x41..0x44 on consecutive cycles, then tx_valid_o=0.
5. FIFO simultaneous push/pop: when full, push 0x55 in the same cycle as a pop. count stays 4, overflow stays 0, and 0x55 is drained last.
6. Reset mid-operation: with 3 bytes queued and irq high, assert rst_i low. tx_valid_o and timer_irq_o are 0 immediately (asynchronous). After release, CONS_STAT reads empty=1 and count=0.
